fx_bypass_ctrl: RTL
===================

# fx_bypass_ctrl

Footswitch-driven engage/bypass sequencer for one effect slot (e.g. the swell / slow-gear block) in the sample-rate audio path. It debounces the footswitch, drives the effect's `enable_i`, waits for the effect's internal delay buffer to prime, then crossfades wet and dry gains so engaging or bypassing never clicks. Gains use the codebase's 9-bit attenuator convention: 256 = unity, 0 = mute. Downstream, two attenuators are summed: wet × `wet_gain_o` plus dry × `dry_gain_o`.

## Interface

Clock and reset: one clock `clk_i`; reset `srst_i` is synchronous and active-high.

Parameters:
- `DEBOUNCE_TICKS`, 480: consecutive sample ticks a footswitch level must hold to be accepted (10 ms at 48 kHz); range 2..65535.
- `PRIME_TICKS`, 1024: sample ticks the effect is enabled at zero wet gain before fade-in; covers a 1023-deep output buffer; range 1..65535.
- `FADE_STEP`, 2: gain change per sample tick during fades; must divide 256.

Ports:
- `clk_i` in 1: system clock.
- `srst_i` in 1: synchronous active-high reset.
- `sample_tick_i` in 1: one-cycle strobe per audio sample.
- `footswitch_i` in 1: raw momentary switch, asynchronous, 1 = pressed.
- `force_bypass_i` in 1: level input, 1 = bypass requested (e.g. patch change).
- `effect_enable_o` out 1: drives the effect's `enable_i`.
- `wet_gain_o` out 9: wet attenuator multiplier, 0..256.
- `dry_gain_o` out 9: dry attenuator multiplier; always 256 − `wet_gain_o`.
- `busy_o` out 1: high in PRIME_S, FADE_IN_S and FADE_OUT_S.
- `state_o` out 3: current state encoding, for debug and LED.

## Operation

- Synchronizer: `footswitch_i` passes through two flops on `clk_i` to give `fs_sync`.
- Debouncer:
  - The counter increments on each `sample_tick_i` where `fs_sync` ≠ `fs_deb`. It clears on any tick where they are equal.
  - When the counter reaches `DEBOUNCE_TICKS` − 1 and another mismatching tick arrives, `fs_deb` takes `fs_sync` and the counter clears.
  - The press event is a one-cycle `toggle` pulse on the `fs_deb` 0→1 edge. Release generates nothing.
- FSM states and their outputs:
  - BYPASS_S: enable 0, wet 0.
  - PRIME_S: enable 1, wet 0; `prime_cnt` counts ticks.
  - FADE_IN_S: enable 1; on each tick wet += `FADE_STEP`, saturating at 256.
  - ACTIVE_S: enable 1, wet 256.
  - FADE_OUT_S: enable 1; on each tick wet −= `FADE_STEP`, saturating at 0.
- FSM transitions (`fb` = `force_bypass_i`):
  - BYPASS_S: on `toggle` with `fb` = 0, go to PRIME_S and clear `prime_cnt`.
  - PRIME_S:
    - On `toggle` or `fb`, go to BYPASS_S.
    - Otherwise, on the tick where `prime_cnt` = `PRIME_TICKS` − 1, go to FADE_IN_S.
  - FADE_IN_S:
    - On `toggle` or `fb`, go to FADE_OUT_S; wet continues from its current value.
    - Otherwise, when wet reaches 256, go to ACTIVE_S.
  - ACTIVE_S: on `toggle` or `fb`, go to FADE_OUT_S.
  - FADE_OUT_S:
    - On `toggle` with `fb` = 0, go to FADE_IN_S from the current wet.
    - On the tick where wet reaches 0, go to BYPASS_S.
- Simultaneous events:
  - If `toggle` and `sample_tick_i` coincide, the toggle transition wins and no gain step happens that cycle.
  - `fb` held high blocks every transition into PRIME_S or FADE_IN_S.
- Width rules:
  - Wet is a 9-bit register.
  - Steps are computed in 10 bits and clamped to 0..256.
  - Dry is derived combinationally as 256 − wet, so wet + dry = 256 in every cycle.

## Timing

- Reset:
  - State BYPASS_S, `effect_enable_o` 0, `wet_gain_o` 0, `dry_gain_o` 256, `busy_o` 0.
  - `fs_deb` 0, all counters 0.
  - A reset asserted mid-fade takes effect on the next edge; there is no fade-out.
- Outputs:
  - `effect_enable_o`, `wet_gain_o` and `state_o` are registered.
  - `dry_gain_o` and `busy_o` are combinational from those registers.
- Latency:
  - `toggle` is asserted 1 cycle after `fs_deb` rises.
  - The state changes on the clock edge after `toggle`.
  - `effect_enable_o` rises in the same cycle the state enters PRIME_S.
- Full engage from BYPASS_S: `PRIME_TICKS` + 256/`FADE_STEP` sample ticks, i.e. 1024 + 128 with defaults.
- Disengage from ACTIVE_S:
  - 128 ticks of fade.
  - `effect_enable_o` falls in the same cycle the state enters BYPASS_S, with wet already 0.

## Test plan

- Reset then idle for 5000 ticks: state BYPASS_S, enable 0, wet 0, dry 256 throughout.
- Debounce: raw high for 479 ticks then low produces no `toggle`. Raw high for 480 ticks produces exactly one `toggle`, and enable rises 2 cycles later.
- Full engage with defaults: wet stays 0 for 1024 ticks, then ramps 2, 4, …, 256 over 128 ticks into ACTIVE_S. Check wet + dry = 256 in every cycle.
- Reversal: a press when wet = 100 in FADE_IN_S gives FADE_OUT_S, with wet 98, 96, … down to 0. Then BYPASS_S, and enable goes low with wet = 0.
- Bounce chatter: raw toggles every 50 ticks for 2000 ticks, then settles high. Exactly one `toggle`, and it lands 480 ticks after the last edge.
- `force_bypass_i` = 1 while in ACTIVE_S: fade-out to BYPASS_S. Presses while it is held are ignored. A press during PRIME_S returns to BYPASS_S on the next edge.

Source files
------------

// File: rtl/fx_bypass_ctrl.sv
// Engage/bypass sequencer for one effect slot: debounces the footswitch, primes the
// effect's delay buffer at zero wet gain, then crossfades wet/dry so switching never clicks.
module fx_bypass_ctrl #(
    parameter int DEBOUNCE_TICKS = 480,
    parameter int PRIME_TICKS    = 1024,
    parameter int FADE_STEP      = 2
) (
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic       sample_tick_i,
    input  logic       footswitch_i,
    input  logic       force_bypass_i,
    output logic       effect_enable_o,
    output logic [8:0] wet_gain_o,
    output logic [8:0] dry_gain_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] BYPASS_S   = 3'd0;
    localparam logic [2:0] PRIME_S    = 3'd1;
    localparam logic [2:0] FADE_IN_S  = 3'd2;
    localparam logic [2:0] ACTIVE_S   = 3'd3;
    localparam logic [2:0] FADE_OUT_S = 3'd4;

    localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_TICKS - 1);
    localparam logic [15:0] PRIME_LAST = 16'(PRIME_TICKS - 1);
    localparam logic [9:0]  STEP       = 10'(FADE_STEP);
    localparam logic [9:0]  UNITY      = 10'd256;

    logic        fs_meta, fs_sync, fs_deb, fs_deb_q, toggle;
    logic [15:0] deb_cnt, prime_cnt;
    logic [9:0]  wet_up, wet_dn;
    logic        fb;

    assign fb = force_bypass_i;

    // Raw switch is asynchronous; a level is accepted only after DEBOUNCE_TICKS
    // consecutive disagreeing sample ticks.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            fs_meta  <= 1'b0;
            fs_sync  <= 1'b0;
            fs_deb   <= 1'b0;
            fs_deb_q <= 1'b0;
            toggle   <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            fs_meta  <= footswitch_i;
            fs_sync  <= fs_meta;
            fs_deb_q <= fs_deb;
            toggle   <= fs_deb & ~fs_deb_q;
            if (sample_tick_i) begin
                if (fs_sync == fs_deb) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_LAST) begin
                    fs_deb  <= fs_sync;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 16'd1;
                end
            end
        end
    end

    // Gain steps in 10 bits so 256 + step and 0 - step clamp cleanly.
    always_comb begin
        wet_up = {1'b0, wet_gain_o} + STEP;
        if (wet_up > UNITY) wet_up = UNITY;
        wet_dn = 10'd0;
        if ({1'b0, wet_gain_o} > STEP) wet_dn = {1'b0, wet_gain_o} - STEP;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_o         <= BYPASS_S;
            effect_enable_o <= 1'b0;
            wet_gain_o      <= 9'd0;
            prime_cnt       <= '0;
        end else begin
            case (state_o)
                BYPASS_S: begin
                    if (toggle && !fb) begin
                        state_o         <= PRIME_S;
                        effect_enable_o <= 1'b1;
                        prime_cnt       <= '0;
                    end
                end
                PRIME_S: begin
                    if (toggle || fb) begin
                        state_o         <= BYPASS_S;
                        effect_enable_o <= 1'b0;
                    end else if (sample_tick_i) begin
                        if (prime_cnt == PRIME_LAST) state_o <= FADE_IN_S;
                        else prime_cnt <= prime_cnt + 16'd1;
                    end
                end
                FADE_IN_S: begin
                    // A toggle on a tick cycle suppresses that tick's gain step.
                    if (toggle || fb) begin
                        state_o <= FADE_OUT_S;
                    end else if (sample_tick_i) begin
                        wet_gain_o <= wet_up[8:0];
                        if (wet_up == UNITY) state_o <= ACTIVE_S;
                    end
                end
                ACTIVE_S: begin
                    if (toggle || fb) state_o <= FADE_OUT_S;
                end
                FADE_OUT_S: begin
                    if (toggle && !fb) begin
                        state_o <= FADE_IN_S;
                    end else if (sample_tick_i) begin
                        wet_gain_o <= wet_dn[8:0];
                        if (wet_dn == 10'd0) begin
                            state_o         <= BYPASS_S;
                            effect_enable_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_o         <= BYPASS_S;
                    effect_enable_o <= 1'b0;
                    wet_gain_o      <= 9'd0;
                end
            endcase
        end
    end

    assign dry_gain_o = 9'd256 - wet_gain_o;
    assign busy_o     = (state_o == PRIME_S) || (state_o == FADE_IN_S) || (state_o == FADE_OUT_S);

endmodule
